// File: rtl/ov7670_stream_gen.sv
// Synthetic OV7670 camera: drives PCLK/VSYNC/HREF/DATA in RGB444 timing from
// built-in test patterns so the capture path can run without a sensor.
//
// Bus timing: vsync, href and data change only on the clk edge where pclk
// falls (a "byte slot") and hold through the next pclk rising edge, where
// the receiver samples them. One byte leaves every two clk cycles.
module ov7670_stream_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_TOTAL  = 784,
    parameter int V_SYNC   = 3,
    parameter int V_BACK   = 17,
    parameter int V_ACTIVE = 480,
    parameter int V_TOTAL  = 510
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    input  logic [1:0]  pattern_sel,
    input  logic [11:0] solid_rgb,
    output logic        pclk,
    output logic        vsync,
    output logic        href,
    output logic [7:0]  data,
    output logic        busy,
    output logic        frame_done,
    output logic [15:0] frame_count,
    output logic        run_state
);

    localparam int HW     = $clog2(2 * H_TOTAL);
    localparam int VW     = $clog2(V_TOTAL);
    localparam int V_ACT0 = V_SYNC + V_BACK;
    localparam int BAR_W  = H_ACTIVE / 8;
    localparam logic [HW-1:0] H_LAST = HW'(2 * H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t      state, state_d;
    logic [HW-1:0] hcnt, hcnt_d;
    logic [VW-1:0] vcnt, vcnt_d;
    logic        vsync_d, href_d, busy_d, frame_done_d;
    logic [7:0]  data_d;
    logic [15:0] frame_count_d;
    logic [1:0]  pat, pat_d;
    logic [11:0] solid, solid_d;

    // Working signals for the slot being emitted
    logic          last_pos;
    logic          emit;
    logic [HW-1:0] nh;
    logic [VW-1:0] nv;
    logic [11:0]   rgb;
    logic          href_n;

    assign run_state = (state == RUN);

    // Colour of pixel (x, y) for the frame's latched pattern
    function automatic logic [11:0] pixel_rgb(input int x, input int y,
                                              input logic [1:0] p,
                                              input logic [11:0] s);
        logic [11:0] c;
        logic [3:0]  ramp;
        c = 12'h000;
        case (p)
            2'd0: begin
                case (x / BAR_W)
                    0:       c = 12'hFFF;
                    1:       c = 12'hFF0;
                    2:       c = 12'h0FF;
                    3:       c = 12'h0F0;
                    4:       c = 12'hF0F;
                    5:       c = 12'hF00;
                    6:       c = 12'h00F;
                    default: c = 12'h000;
                endcase
            end
            2'd1: begin
                ramp = 4'(x >> 2);
                c    = {ramp, ramp, ramp};
            end
            2'd2:    c = (x[5] ^ y[5]) ? 12'hFFF : 12'h000;
            default: c = s;
        endcase
        return c;
    endfunction

    // Free-running pixel clock at clk/2
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) pclk <= 1'b0;
        else          pclk <= ~pclk;
    end

    // State and output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            hcnt        <= '0;
            vcnt        <= '0;
            vsync       <= 1'b0;
            href        <= 1'b0;
            data        <= 8'h00;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
            frame_count <= 16'h0000;
            pat         <= 2'd0;
            solid       <= 12'h000;
        end else begin
            state       <= state_d;
            hcnt        <= hcnt_d;
            vcnt        <= vcnt_d;
            vsync       <= vsync_d;
            href        <= href_d;
            data        <= data_d;
            busy        <= busy_d;
            frame_done  <= frame_done_d;
            frame_count <= frame_count_d;
            pat         <= pat_d;
            solid       <= solid_d;
        end
    end

    // Next state, counter advance and the byte for the next slot
    always_comb begin
        state_d       = state;
        hcnt_d        = hcnt;
        vcnt_d        = vcnt;
        vsync_d       = vsync;
        href_d        = href;
        data_d        = data;
        busy_d        = busy;
        frame_done_d  = 1'b0;
        frame_count_d = frame_count;
        pat_d         = pat;
        solid_d       = solid;
        emit          = 1'b0;
        nh            = '0;
        nv            = '0;
        rgb           = 12'h000;
        href_n        = 1'b0;
        last_pos      = (vcnt == V_LAST) && (hcnt == H_LAST);

        if (!pclk) begin
            // Mid-slot edge: the cycle that follows is the frame's last clk
            if (state == RUN && last_pos) begin
                frame_done_d  = 1'b1;
                frame_count_d = frame_count + 16'd1;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (enable) begin
                        state_d = RUN;
                        emit    = 1'b1;
                        pat_d   = pattern_sel;
                        solid_d = solid_rgb;
                    end
                end
                default: begin
                    if (last_pos) begin
                        if (enable) begin
                            emit    = 1'b1;
                            pat_d   = pattern_sel;
                            solid_d = solid_rgb;
                        end else begin
                            state_d = IDLE;
                            hcnt_d  = '0;
                            vcnt_d  = '0;
                            vsync_d = 1'b0;
                            href_d  = 1'b0;
                            data_d  = 8'h00;
                            busy_d  = 1'b0;
                        end
                    end else begin
                        emit = 1'b1;
                        if (hcnt == H_LAST) begin
                            nh = '0;
                            nv = vcnt + 1'b1;
                        end else begin
                            nh = hcnt + 1'b1;
                            nv = vcnt;
                        end
                    end
                end
            endcase
        end

        if (emit) begin
            rgb     = pixel_rgb(int'(nh >> 1), int'(nv) - V_ACT0, pat_d, solid_d);
            href_n  = (int'(nv) >= V_ACT0) && (int'(nv) < V_ACT0 + V_ACTIVE) &&
                      (int'(nh) < 2 * H_ACTIVE);
            hcnt_d  = nh;
            vcnt_d  = nv;
            busy_d  = 1'b1;
            vsync_d = (int'(nv) < V_SYNC);
            href_d  = href_n;
            if (!href_n)    data_d = 8'h00;
            else if (nh[0]) data_d = rgb[7:0];
            else            data_d = {4'h0, rgb[11:8]};
        end
    end

endmodule

// File: tb/tb_ov7670_stream_gen.sv
// Self-checking bench for ov7670_stream_gen using a small-frame geometry.
module tb_ov7670_stream_gen;

    localparam int HA = 8;
    localparam int HT = 12;
    localparam int VS = 1;
    localparam int VB = 2;
    localparam int VA = 4;
    localparam int VT = 8;
    localparam int FRAME_CLK = 4 * HT * VT;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        enable = 1'b0;
    logic [1:0]  pattern_sel = 2'd0;
    logic [11:0] solid_rgb = 12'h000;
    logic        pclk, vsync, href, busy, frame_done, run_state;
    logic [7:0]  data;
    logic [15:0] frame_count;

    logic [9:0]  exp_q[$];
    int          checks = 0;
    int          passes = 0;
    int          model_count = 0;
    logic [11:0] bars [8];

    ov7670_stream_gen #(
        .H_ACTIVE(HA), .H_TOTAL(HT), .V_SYNC(VS),
        .V_BACK(VB), .V_ACTIVE(VA), .V_TOTAL(VT)
    ) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable),
        .pattern_sel(pattern_sel), .solid_rgb(solid_rgb),
        .pclk(pclk), .vsync(vsync), .href(href), .data(data),
        .busy(busy), .frame_done(frame_done), .frame_count(frame_count),
        .run_state(run_state)
    );

    // clock
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: the whole frame's slot sequence {vsync, href, data}
    task automatic push_frame(input logic [1:0] p, input logic [11:0] s);
        for (int v = 0; v < VT; v++) begin
            for (int h = 0; h < 2 * HT; h++) begin
                int          x, y;
                logic        vs_b, hr_b;
                logic [11:0] c;
                logic [7:0]  b;
                x    = h / 2;
                y    = v - (VS + VB);
                vs_b = (v < VS);
                hr_b = (v >= VS + VB) && (v < VS + VB + VA) && (h < 2 * HA);
                case (p)
                    2'd0:    c = bars[x / (HA / 8)];
                    2'd1:    c = {3{4'((x / 4) % 16)}};
                    2'd2:    c = (((x / 32) + (y / 32)) % 2 == 1) ? 12'hFFF : 12'h000;
                    default: c = s;
                endcase
                if (!hr_b)         b = 8'h00;
                else if (h % 2)    b = c[7:0];
                else               b = {4'h0, c[11:8]};
                exp_q.push_back({vs_b, hr_b, b});
            end
        end
    endtask

    // Monitor: every byte slot while busy pops one expected byte
    initial begin : monitor
        logic [9:0] e;
        logic       prev_fd;
        prev_fd = 1'b0;
        forever begin
            @(negedge clk);
            if (frame_done) check("frame_done_one_clk", {31'd0, prev_fd}, 0);
            prev_fd = frame_done;
            if (reset_n && !pclk) begin
                if (busy) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        $display("FAIL byte_unexpected: got %0h with no byte expected at %0t",
                                 {vsync, href, data}, $time);
                    end else begin
                        e = exp_q.pop_front();
                        check("slot_byte", {22'd0, vsync, href, data}, {22'd0, e});
                    end
                end else begin
                    check("idle_bus", {22'd0, vsync, href, data}, 0);
                end
            end
        end
    end

    // Driver: wait for a negedge where the next posedge is a byte slot
    task automatic wait_slot_phase();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!pclk && n < 4);
        check("pclk_phase", {31'd0, pclk}, 1);
    endtask

    task automatic start_from_idle(input logic [1:0] p, input logic [11:0] s);
        pattern_sel = p;
        solid_rgb   = s;
        wait_slot_phase();
        check("idle_before_start", {31'd0, busy}, 0);
        push_frame(p, s);
        enable = 1'b1;
    endtask

    // Run the current frame to its end; change inputs (and maybe drop enable) at clk 100
    task automatic run_frame(input bit drop, input logic [1:0] np, input logic [11:0] ns);
        int cnt;
        bit seen;
        cnt  = 0;
        seen = 0;
        while (cnt < FRAME_CLK + 50 && !seen) begin
            @(negedge clk);
            cnt++;
            if (cnt == 100) begin
                pattern_sel = np;
                solid_rgb   = ns;
                if (drop) enable = 1'b0;
            end
            if (frame_done) seen = 1;
        end
        check("frame_period", cnt, FRAME_CLK);
        model_count++;
        check("frame_count", {16'd0, frame_count}, model_count);
        if (enable) push_frame(pattern_sel, solid_rgb);
    endtask

    task automatic check_stopped();
        @(negedge clk);
        check("busy_fell", {31'd0, busy}, 0);
        check("state_idle", {31'd0, run_state}, 0);
        repeat (40) @(negedge clk);
        check("still_idle", {31'd0, busy}, 0);
    endtask

    initial begin : stimulus
        int  n;
        bit  href_seen;
        bars = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0, 12'hF0F, 12'hF00, 12'h00F, 12'h000};

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_pclk", {31'd0, pclk}, 0);
        check("rst_bus", {22'd0, vsync, href, data}, 0);
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_frame_done", {31'd0, frame_done}, 0);
        check("rst_frame_count", {16'd0, frame_count}, 0);
        reset_n = 1'b1;

        // Idle: pclk toggles each clk, nothing else moves
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            check("idle_pclk", {31'd0, pclk}, (i % 2 == 0) ? 1 : 0);
            check("idle_busy", {31'd0, busy}, 0);
        end

        // Colour bars, then solid ABC, solid 123, random, and a stop
        start_from_idle(2'd0, 12'(($urandom_range(0, 4095))));
        run_frame(0, 2'd3, 12'hABC);
        run_frame(0, 2'd3, 12'h123);
        run_frame(0, 2'($urandom_range(0, 3)), 12'($urandom_range(0, 4095)));
        run_frame(0, 2'($urandom_range(0, 3)), 12'($urandom_range(0, 4095)));
        run_frame(1, 2'($urandom_range(0, 3)), 12'($urandom_range(0, 4095)));
        check_stopped();

        // Asynchronous reset in the middle of an active line
        start_from_idle(2'($urandom_range(0, 3)), 12'($urandom_range(0, 4095)));
        n = 0;
        href_seen = 0;
        while (n < FRAME_CLK && !href_seen) begin
            @(negedge clk);
            n++;
            if (href) href_seen = 1;
        end
        check("href_reached", {31'd0, href_seen}, 1);
        #2;
        reset_n = 1'b0;
        enable  = 1'b0;
        #1;
        check("async_href", {31'd0, href}, 0);
        check("async_data", {24'd0, data}, 0);
        check("async_busy", {31'd0, busy}, 0);
        check("async_frame_count", {16'd0, frame_count}, 0);
        exp_q.delete();
        model_count = 0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;

        // Restart after reset begins at vcnt=0 with vsync
        start_from_idle(2'($urandom_range(0, 3)), 12'($urandom_range(0, 4095)));
        run_frame(1, 2'($urandom_range(0, 3)), 12'($urandom_range(0, 4095)));
        check_stopped();

        check("queue_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/ov7670_stream_gen.md
Name: ov7670_stream_gen

Overview:
Synthetic OV7670 sensor. Generates the camera-side pixel bus (PCLK, VSYNC, HREF, 8-bit DATA) in RGB444 VGA timing, so the capture path and frame buffer can be exercised on a board without a camera and in simulation. Sits in place of the OV7670 pins and feeds the capture block directly. Pixels come from built-in test patterns selected at frame granularity.

Parameters:
H_ACTIVE, 640, active pixels per line
H_TOTAL, 784, total pixel periods per line (active + blank)
V_SYNC, 3, lines with VSYNC high at frame start
V_BACK, 17, blank lines between VSYNC end and first active line
V_ACTIVE, 480, active lines per frame
V_TOTAL, 510, total lines per frame

Ports:
clk  in  1  system clock; PCLK runs at clk/2
reset_n  in  1  asynchronous active-low reset
enable  in  1  level; run frames while high
pattern_sel  in  2  0 colour bars, 1 ramp, 2 checkerboard, 3 solid
solid_rgb  in  12  {R,G,B} nibbles for pattern 3
pclk  out  1  generated pixel clock
vsync  out  1  frame sync, active high
href  out  1  line valid, active high
data  out  8  pixel byte
busy  out  1  high while a frame is in progress
frame_done  out  1  one-clk pulse on the last clk of each frame
frame_count  out  16  frames completed since reset; wraps

Behaviour:
- Reset: pclk, vsync, href, data, busy, frame_done, frame_count all 0. The FSM goes to IDLE and the counters clear.
- pclk is a register that toggles every clk from the first edge after reset, free-running in every state.
- Byte slot:
  - vsync, href and data update only on the clk edge where pclk goes 1->0.
  - They are stable across the following pclk rising edge, which is where the capture block samples them.
  - One byte is produced per 2 clk.
- Counters (advance on byte slots):
  - hcnt runs 0..2*H_TOTAL-1.
  - vcnt runs 0..V_TOTAL-1 and increments when hcnt wraps.
  - Pixel x = hcnt>>1. Byte phase = hcnt[0].
  - y = vcnt-(V_SYNC+V_BACK).
- FSM:
  - IDLE: vsync/href/data held 0, counters 0, busy 0. Leaves IDLE when enable=1 is seen on a byte slot.
  - RUN: that same slot emits vcnt=0, hcnt=0. busy=1.
  - End of frame (vcnt=V_TOTAL-1, hcnt=2*H_TOTAL-1):
    - frame_done pulses and frame_count increments.
    - If enable=1, stay in RUN and wrap both counters to 0.
    - Else return to IDLE.
  - Dropping enable mid-frame never truncates a frame.
- Timing within RUN:
  - vsync = (vcnt < V_SYNC).
  - href = (vcnt in [V_SYNC+V_BACK, V_SYNC+V_BACK+V_ACTIVE)) and (hcnt < 2*H_ACTIVE).
  - data = 0 whenever href=0.
- Byte format (RGB444 xR GB):
  - Phase 0 byte = {4'h0, R}.
  - Phase 1 byte = {G, B}.
- Patterns (12-bit {R,G,B}):
  - 0: 8 bars, each H_ACTIVE/8 wide, left to right: FFF, FF0, 0FF, 0F0, F0F, F00, 00F, 000.
  - 1: R=G=B=x[5:2].
  - 2: (x[5]^y[5]) ? FFF : 000.
  - 3: solid_rgb.
- pattern_sel and solid_rgb are latched at frame start (the vcnt=0, hcnt=0 slot). Changes mid-frame take effect on the next frame.
- reset_n asserted mid-frame: all outputs return to 0 immediately (asynchronous), the FSM goes to IDLE, and frame_count clears.

Test Plan:
All tests use H_ACTIVE=8, H_TOTAL=12, V_SYNC=1, V_BACK=2, V_ACTIVE=4, V_TOTAL=8. One frame = 4*12*8 = 384 clk.
1. Reset, enable=0 for 100 clk -> pclk toggles every clk; vsync/href/data/busy stay 0.
2. enable=1 held, pattern_sel=0:
   - vsync high for 48 clk, then 96 clk gap with href low.
   - Then 4 lines, each with href high 32 clk then low 16 clk.
   - Line bytes: 0F,FF,0F,F0,00,FF,00,F0,0F,0F,0F,00,00,0F,00,00.
3. Continuous enable:
   - frame_done pulses every 384 clk.
   - frame_count reads 1,2,3 after 3 frames.
   - No gap between frames (vsync re-asserts on the next byte slot).
4. pattern_sel=3, solid_rgb=ABC; change to 123 mid-frame -> rest of that frame emits 0A,BC; next frame emits 01,23.
5. Deassert enable at clk 100 of a frame -> frame completes to 384, frame_done pulses, busy falls, outputs held 0.
6. reset_n low mid-href -> href, data, busy, frame_count go 0 asynchronously. After release, re-enable starts at vcnt=0 with vsync.
